// File: rtl/mac_seq_ctrl_if.sv
// Job, operand and result handshake bundle between the operand source and
// the MAC sequencer.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 4
) ();
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [15:0]      cfg_bias;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             ovf;

    modport master (
        output start, cfg_len, cfg_bias, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  start, cfg_len, cfg_bias, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: primes the external MAC with a bias, streams operand pairs
// into it with the registered result fed back as addend, then holds the
// dot-product on a valid/ready result port.
module mac_seq_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    mac_seq_ctrl_if.slave bus,
    output logic [7:0]    mac_a,
    output logic [7:0]    mac_b,
    output logic [15:0]   mac_c,
    input  logic [15:0]   mac_y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             beat;
    logic             start_ok;
    logic [15:0]      prod;
    logic             carry;

    assign beat     = (state == RUN) && bus.in_valid;
    assign start_ok = reset && bus.start && (state == IDLE);

    // MAC input steering: clear, prime, accumulate or hold depending on state
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (reset) begin
            case (state)
                IDLE: if (start_ok) mac_c = bus.cfg_bias;
                RUN: begin
                    mac_c = mac_y;
                    if (bus.in_valid) begin
                        mac_a = bus.in_a;
                        mac_b = bus.in_b;
                    end
                end
                DONE: mac_c = mac_y;
                default: ;
            endcase
        end
    end

    // Bit 16 of {1'b0,mac_y}+prod, expressed as a compare so no unused
    // low sum bits are produced: the sum carries iff mac_y > 0xFFFF - prod.
    always_comb begin
        prod  = {8'd0, mac_a} * {8'd0, mac_b};
        carry = (mac_y > (16'hFFFF - prod));
    end

    assign bus.out_data = bus.out_valid ? mac_y : '0;

    // Sequencer FSM with registered status outputs and sticky carry flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            rem           <= '0;
            bus.ovf       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        bus.ovf  <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.cfg_len == '0) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                        end else begin
                            rem          <= bus.cfg_len;
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        rem <= rem - 1'b1;
                        if (carry) bus.ovf <= 1'b1;
                        if (rem == LEN_W'(1)) begin
                            state         <= DONE;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC model, directed jobs, and a
// scoreboard monitor that checks each accepted result.
module tb_mac_seq_ctrl;
    logic        clk;
    logic        reset;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_c;
    logic [15:0] mac_y;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb_q[$];

    mac_seq_ctrl_if #(.LEN_W(4)) bus ();

    mac_seq_ctrl #(.LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .mac_a (mac_a),
        .mac_b (mac_b),
        .mac_c (mac_c),
        .mac_y (mac_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: one-cycle registered y <= a*b + c, wraps mod 2^16
    always @(posedge clk) mac_y <= 16'(16'(mac_a) * 16'(mac_b) + mac_c);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each accepted result against the queue
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                if ({bus.ovf, bus.out_data} !== e) begin
                    fails++;
                    $display("FAIL result: got ovf=%0b data=%0h expected ovf=%0b data=%0h",
                             bus.ovf, bus.out_data, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job: pairs packed high byte first; gap = idle cycles between
    // beats (with stray start pulses), bp = cycles of out_ready low.
    task automatic do_job(input int len, input logic [15:0] bias,
                          input logic [23:0] av, input logic [23:0] bv,
                          input int gap, input int bp,
                          input logic [15:0] exp_data, input logic exp_ovf);
        sb_q.push_back({exp_ovf, exp_data});
        bus.start    = 1'b1;
        bus.cfg_len  = 4'(len);
        bus.cfg_bias = bias;
        bus.out_ready = (bp == 0);
        tick();
        bus.start = 1'b0;
        if (len == 0) check("zero_len_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    bus.start    = 1'b1;
                    tick();
                    bus.start = 1'b0;
                end
            end
            check("in_ready_on_beat", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b1;
            bus.in_a     = av[23-8*i -: 8];
            bus.in_b     = bv[23-8*i -: 8];
            tick();
            bus.in_valid = 1'b0;
        end
        check("out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
        check("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
        for (int k = 0; k < bp; k++) begin
            bus.start = 1'b1;
            #1;
            check("hold_data", {16'd0, bus.out_data}, {16'd0, exp_data});
            check("hold_ovf", {31'd0, bus.ovf}, {31'd0, exp_ovf});
            tick();
            bus.start = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_accept", {30'd0, bus.busy, bus.out_valid}, 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b1;
        bus.cfg_len   = 4'd3;
        bus.cfg_bias  = 16'h5555;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_status", {27'd0, bus.busy, bus.in_ready, bus.out_valid, bus.ovf, 1'b0}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_mac_in", {mac_a, mac_b, mac_c}, 32'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        check("rst_mac_y", {16'd0, mac_y}, 32'd0);
        tick();

        // basic: 10 + 2*3 + 4*5 + 1*1 = 37
        do_job(3, 16'd10, {8'd2, 8'd4, 8'd1}, {8'd3, 8'd5, 8'd1}, 0, 0, 16'd37, 1'b0);
        // stalls, backpressure and stray starts
        do_job(3, 16'd10, {8'd2, 8'd4, 8'd1}, {8'd3, 8'd5, 8'd1}, 2, 5, 16'd37, 1'b0);
        // zero length returns the bias
        do_job(0, 16'h1234, 24'd0, 24'd0, 0, 1, 16'h1234, 1'b0);
        // 0xFFF0 + 0xFE01 carries -> 0xFDF1, +1 -> 0xFDF2
        do_job(2, 16'hFFF0, {8'd255, 8'd1, 8'd0}, {8'd255, 8'd1, 8'd0}, 0, 2, 16'hFDF2, 1'b1);
        do_job(1, 16'd0, {8'd1, 16'd0}, {8'd1, 16'd0}, 0, 0, 16'd1, 1'b0);

        // reset after the first of three beats
        bus.start    = 1'b1;
        bus.cfg_len  = 4'd3;
        bus.cfg_bias = 16'd0;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd7;
        bus.in_b     = 8'd7;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_busy_ready", {30'd0, bus.busy, bus.in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("midrst_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
            tick();
        end
        bus.out_ready = 1'b0;
        do_job(1, 16'd0, {8'd3, 16'd0}, {8'd3, 16'd0}, 0, 0, 16'd9, 1'b0);

        tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the chip's 8x8+16 MAC unit. It accepts a job (vector length and 16-bit bias), streams operand pairs into the MAC one per cycle, and feeds the MAC's registered result back as the addend. It then presents the final dot-product through a valid/ready result port. It sits between the operand source and `mac_unit` at the `chip1_tinyml` level and owns the MAC's `a`/`b`/`c` inputs exclusively.

## Interface
- `LEN_W`, default 4: width of the job length; maximum vector length is 2^LEN_W-1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_len`  in  LEN_W  number of operand pairs; captured with `start`.
- `cfg_bias`  in  16  initial accumulator value; applied on the `start` cycle.
- `busy`  out  1  high in every state other than IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in RUN.
- `in_a`, `in_b`  in  8 each  unsigned operands.
- `mac_a`, `mac_b`  out  8 each  drive the MAC `a`/`b` inputs (combinational).
- `mac_c`  out  16  drives the MAC `c` input (combinational).
- `mac_y`  in  16  MAC registered result; 1-cycle latency, y <= a*b+c.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  result consumed.
- `out_data`  out  16  equals `mac_y` in DONE; 0 otherwise.
- `ovf`  out  1  sticky carry-out flag for the current job; valid with `out_valid`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. A `rem` register (LEN_W bits) counts the pairs still to be accepted.
- IDLE, no `start`:
  - drive `mac_a`=`mac_b`=0 and `mac_c`=0, so the MAC clears to 0 the next cycle.
- IDLE, `start`=1:
  - drive `mac_c`=`cfg_bias` with `mac_a`=`mac_b`=0, so the MAC primes to the bias.
  - clear `ovf`.
  - if `cfg_len`=0, go to DONE; otherwise set `rem`=`cfg_len` and go to RUN.
- RUN:
  - a beat is `in_valid` & `in_ready`.
  - on a beat: `mac_a`=`in_a`, `mac_b`=`in_b`, `mac_c`=`mac_y`; decrement `rem`.
  - with no beat: `mac_a`=`mac_b`=0 and `mac_c`=`mac_y`, so the accumulator holds.
  - on the beat where `rem`=1, go to DONE.
- DONE:
  - drive `mac_a`=`mac_b`=0 and `mac_c`=`mac_y`, so the result holds stable.
  - `out_valid`=1.
  - when `out_valid` & `out_ready`, go to IDLE.
- `start` outside IDLE is ignored; `cfg_*` are sampled only with an accepted `start`.
- Arithmetic:
  - the MAC wraps modulo 2^16.
  - the controller computes the 17-bit sum {1'b0,`mac_y`} + `mac_a`*`mac_b` on every RUN beat.
  - if bit 16 of that sum is set, `ovf` is set; it stays set until the next accepted `start`.
- Reset, including mid-job:
  - state goes to IDLE; `rem`=0; `ovf`=0.
  - the job is discarded with no `out_valid`.
  - `start` is masked while `reset`=0, so the MAC inputs are driven 0/0/0.

## Timing
- Values at reset:
  - `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `ovf`=0.
  - `mac_a`=`mac_b`=`mac_c`=0.
  - `mac_y` reads 0 one cycle later.
- Without stalls, for length N≥1:
  - `start` is at cycle 0.
  - beats occur in cycles 1..N.
  - `out_valid` rises at cycle N+1 with the final value already on `mac_y`.
- Without stalls, for length 0: `out_valid` rises at cycle 1 with `out_data`=`cfg_bias`.
- Throughput is one pair per cycle. Each `in_valid` gap adds exactly one cycle.
- `out_data` and `ovf` stay stable while `out_valid`=1 and `out_ready`=0.
- After the result is accepted: IDLE on the next cycle, and `start` is accepted in that IDLE cycle. Minimum job-to-job spacing is therefore N+2 cycles.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, with `start`=1 -> all outputs 0, and `mac_y`=0 after release.
- Basic job: `cfg_len`=3, bias=10, pairs (2,3),(4,5),(1,1), no stalls -> `in_ready` in cycles 1-3; `out_valid` at cycle 4 with `out_data`=37 and `ovf`=0.
- Stalls and backpressure, same job:
  - stimulus: `in_valid` low for 2 cycles between pairs; `out_ready` low for 5 cycles; `start` pulsed during RUN and DONE.
  - response: `out_data`=37 held stable; the extra `start` pulses have no effect.
  - IDLE follows the cycle after `out_ready`.
- Zero length: `cfg_len`=0, bias=0x1234 -> `in_ready` never asserts; `out_valid` at cycle 1 with `out_data`=0x1234.
- Overflow: `cfg_len`=2, bias=0xFFF0, pairs (255,255),(1,1) -> `out_data`=0xFDF2 with `ovf`=1; the next job (len 1, bias 0, pair (1,1)) gives `ovf`=0 and `out_data`=1.
- Reset mid-job: reset after the first of 3 beats -> `busy`=0 and `in_ready`=0 the next cycle, with no `out_valid`; a new job (len 1, bias 0, pair (3,3)) gives `out_data`=9.
